// File: rtl/heartbeat_scheduler.sv
// Heartbeat scheduler: per-channel period counters driven by a divided tick,
// feeding a round-robin valid/ready event offer with sticky overrun flags.
module heartbeat_lane #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          active,
  input  logic          tick,
  input  logic          acc_hit,
  input  logic          ovr_clr,
  input  logic [PW-1:0] period,
  output logic          pending,
  output logic          ovr
);
  logic [PW-1:0] cnt;
  logic [PW-1:0] reload;
  logic          fire;

  assign reload = (period == '0) ? '0 : period - PW'(1);
  assign fire   = run && active && tick && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      // First cycle after reset behaves like activation: load, never fire.
      if (!run || !active) cnt <= reload;
      else if (tick)       cnt <= (cnt == '0) ? reload : cnt - PW'(1);

      // A fire in the accepting cycle keeps the bit set without overrun.
      if (fire)                     pending <= 1'b1;
      else if (acc_hit || !active)  pending <= 1'b0;

      ovr <= (fire && pending && !acc_hit) || (ovr && !ovr_clr);
    end
  end
endmodule

module heartbeat_scheduler #(
  parameter int NCH = 4,
  parameter int PW  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_lvl,
  input  logic [NCH-1:0]          cfg_en,
  input  logic [NCH*PW-1:0]       cfg_period,
  output logic                    evt_valid,
  output logic [$clog2(NCH)-1:0]  evt_ch,
  input  logic                    evt_ready,
  output logic [NCH-1:0]          ovr_flag,
  input  logic [NCH-1:0]          ovr_clr,
  output logic [NCH-1:0]          pending
);
  localparam int CW = $clog2(NCH);

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nxt;

  logic                   tick_q, run, tick, accept;
  logic [CW-1:0]          rr_ptr, rr_nxt, ch_nxt, sel, sel_hi, sel_lo;
  logic                   hi_hit;
  logic [NCH-1:0]         active, acc_hit;
  logic [NCH-1:0][PW-1:0] period;

  assign period    = cfg_period;
  assign tick      = tick_lvl & ~tick_q;
  assign evt_valid = (state == OFFER);
  assign accept    = evt_valid & evt_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign active[i]  = cfg_en[i] && (period[i] != '0);
    assign acc_hit[i] = accept && (evt_ch == CW'(i));

    heartbeat_lane #(.PW(PW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .active  (active[i]),
      .tick    (tick),
      .acc_hit (acc_hit[i]),
      .ovr_clr (ovr_clr[i]),
      .period  (period[i]),
      .pending (pending[i]),
      .ovr     (ovr_flag[i])
    );
  end

  // Descending scan leaves the lowest match; prefer indices at/above rr_ptr.
  always_comb begin
    hi_hit = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (pending[i]) sel_lo = CW'(i);
      if (pending[i] && (CW'(i) >= rr_ptr)) begin
        sel_hi = CW'(i);
        hi_hit = 1'b1;
      end
    end
    sel = hi_hit ? sel_hi : sel_lo;
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = evt_ch;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (|pending) begin
        state_nxt = OFFER;
        ch_nxt    = sel;
      end
      OFFER: if (evt_ready) begin
        state_nxt = IDLE;
        rr_nxt    = (evt_ch == CW'(NCH-1)) ? '0 : evt_ch + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      run    <= 1'b0;
      state  <= IDLE;
      evt_ch <= '0;
      rr_ptr <= '0;
    end else begin
      tick_q <= tick_lvl;
      run    <= 1'b1;
      state  <= state_nxt;
      evt_ch <= ch_nxt;
      rr_ptr <= rr_nxt;
    end
  end
endmodule

// File: tb/tb_heartbeat_scheduler.sv
// Directed bench for heartbeat_scheduler: cycle table for steady-state
// scheduling plus hand sequences for stall, overrun, disable and reset cases.
module tb_heartbeat_scheduler;
  localparam int NCH = 4;
  localparam int PW  = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                tick_lvl = 1'b0;
  logic                evt_ready = 1'b0;
  logic                evt_valid;
  logic [1:0]          evt_ch;
  logic [NCH-1:0]      cfg_en = '0;
  logic [NCH-1:0]      ovr_clr = '0;
  logic [NCH-1:0]      ovr_flag;
  logic [NCH-1:0]      pending;
  logic [NCH*PW-1:0]   cfg_period = '0;

  int checks = 0;
  int errors = 0;
  int ev1    = 0;
  int n1     = 0;

  always #5 clk = ~clk;

  heartbeat_scheduler #(.NCH(NCH), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_lvl   (tick_lvl),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready),
    .ovr_flag   (ovr_flag),
    .ovr_clr    (ovr_clr),
    .pending    (pending)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [15:0] per;
    logic        tick;
    logic        rdy;
    logic        vld;
    logic [1:0]  ch;
    logic [3:0]  pend;
    logic [3:0]  ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int en, int per, int tick, int rdy,
                              int vld, int ch, int pend, int ovr);
    vec_t v;
    v.rst  = 1'(rst);
    v.en   = 4'(en);
    v.per  = 16'(per);
    v.tick = 1'(tick);
    v.rdy  = 1'(rdy);
    v.vld  = 1'(vld);
    v.ch   = 2'(ch);
    v.pend = 4'(pend);
    v.ovr  = 4'(ovr);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic t, input logic r, input logic [3:0] clr);
    tick_lvl  = t;
    evt_ready = r;
    ovr_clr   = clr;
    step();
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [15:0] per);
    rst_n      = 1'b0;
    tick_lvl   = 1'b0;
    evt_ready  = 1'b0;
    ovr_clr    = '0;
    cfg_en     = en;
    cfg_period = {NCH{per}};
    #1;
    chk("reset evt_valid", 32'(evt_valid), 0);
    chk("reset evt_ch",    32'(evt_ch),    0);
    chk("reset pending",   32'(pending),   0);
    chk("reset ovr_flag",  32'(ovr_flag),  0);
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    // ch0 period 3, always ready; tick held high later must not re-count
    tbl.push_back(mk(1, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 1, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 1, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 1, 0, 'b0001, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 1, 1, 0, 0, 'b0000, 0));
    tbl.push_back(mk(0, 'b0001, 3, 0, 1, 0, 0, 'b0000, 0));
    n1 = tbl.size();
    // all channels period 1: round-robin order and overrun on ch3
    tbl.push_back(mk(1, 'b1111, 1, 1, 1, 0, 0, 'b1111, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 1, 0, 'b1111, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 0, 0, 'b1110, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 1, 1, 'b1110, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 0, 0, 'b1100, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 1, 2, 'b1100, 'b0000));
    tbl.push_back(mk(0, 'b1111, 1, 1, 1, 0, 0, 'b1111, 'b1000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 1, 3, 'b1111, 'b1000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 0, 0, 'b0111, 'b1000));
    tbl.push_back(mk(0, 'b1111, 1, 0, 1, 1, 0, 'b0111, 'b1000));

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset(tbl[k].en, tbl[k].per);
      cfg_en     = tbl[k].en;
      cfg_period = {NCH{tbl[k].per}};
      tick_lvl   = tbl[k].tick;
      evt_ready  = tbl[k].rdy;
      ovr_clr    = '0;
      step();
      if (k < n1 && evt_valid) ev1++;
      chk($sformatf("row%0d evt_valid", k), 32'(evt_valid), 32'(tbl[k].vld));
      if (tbl[k].vld) chk($sformatf("row%0d evt_ch", k), 32'(evt_ch), 32'(tbl[k].ch));
      chk($sformatf("row%0d pending", k), 32'(pending), 32'(tbl[k].pend));
      chk($sformatf("row%0d ovr_flag", k), 32'(ovr_flag), 32'(tbl[k].ovr));
    end
    chk("period3 event count", 32'(ev1), 3);

    // enabled channel with period 0 never fires
    do_reset(4'b0010, 16'd0);
    for (int i = 0; i < 20; i++) begin
      tick_lvl  = (i % 2 == 0);
      evt_ready = 1'b1;
      step();
      chk($sformatf("period0 cyc%0d valid/pending", i), 32'({evt_valid, pending[1]}), 0);
    end

    // ch2 period 1 stalled: hold offer, overrun, clear, set-wins, disable
    do_reset(4'b0100, 16'd1);
    cyc(1'b1, 1'b0, 4'b0000);
    chk("stall fire pending", 32'(pending), 'b0100);
    cyc(1'b0, 1'b0, 4'b0000);
    chk("stall offer valid", 32'(evt_valid), 1);
    chk("stall offer ch", 32'(evt_ch), 2);
    cyc(1'b1, 1'b0, 4'b0000);
    chk("stall hold valid", 32'(evt_valid), 1);
    chk("stall overrun", 32'(ovr_flag), 'b0100);
    cyc(1'b0, 1'b0, 4'b0000);
    chk("stall hold ch", 32'(evt_ch), 2);
    chk("overrun sticky", 32'(ovr_flag), 'b0100);
    cyc(1'b0, 1'b0, 4'b0100);
    chk("ovr_clr clears", 32'(ovr_flag), 0);
    chk("ovr_clr valid kept", 32'(evt_valid), 1);
    cyc(1'b1, 1'b0, 4'b0100);
    chk("set beats clear", 32'(ovr_flag), 'b0100);
    cfg_en = 4'b0000;
    cyc(1'b0, 1'b0, 4'b0000);
    chk("disable keeps offer", 32'(evt_valid), 1);
    chk("disable keeps ch", 32'(evt_ch), 2);
    chk("disable clears pending", 32'(pending), 0);
    cfg_en = 4'b0100;
    cyc(1'b1, 1'b0, 4'b0000);
    chk("reenable fires", 32'(pending), 'b0100);
    chk("reenable no new ovr", 32'(ovr_flag), 'b0100);

    // asynchronous reset in the middle of an offer
    rst_n = 1'b0;
    #1;
    chk("midreset evt_valid", 32'(evt_valid), 0);
    chk("midreset pending", 32'(pending), 0);
    chk("midreset ovr_flag", 32'(ovr_flag), 0);
    cfg_en     = 4'b0001;
    cfg_period = {NCH{16'd2}};
    tick_lvl   = 1'b0;
    evt_ready  = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    cyc(1'b1, 1'b1, 4'b0000);
    chk("post-reset tick1 pending", 32'(pending), 0);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("post-reset idle valid", 32'(evt_valid), 0);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("post-reset tick2 pending", 32'(pending), 'b0001);
    chk("post-reset tick2 valid", 32'(evt_valid), 0);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("post-reset offer valid", 32'(evt_valid), 1);
    chk("post-reset offer ch", 32'(evt_ch), 0);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("post-reset accepted", 32'({evt_valid, pending}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/heartbeat_scheduler.md
HEARTBEAT_SCHEDULER -- requirements
Module: heartbeat_scheduler

Interface
REQ-001 Parameter NCH, default 4, number of scheduled channels (2..8).
REQ-002 Parameter PW, default 16, width of each channel period field in base ticks.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_lvl  input  1  heartbeat level from the clk-domain clock divider; each rising edge is one base tick.
REQ-006 cfg_en  input  NCH  per-channel enable.
REQ-007 cfg_period  input  NCH*PW  per-channel period in base ticks, channel i at bits [i*PW +: PW].
REQ-008 evt_valid  output  1  scheduled event offered.
REQ-009 evt_ch  output  $clog2(NCH)  channel index of offered event.
REQ-010 evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-011 ovr_flag  output  NCH  sticky per-channel overrun.
REQ-012 ovr_clr  input  NCH  write-one-to-clear pulse for ovr_flag.
REQ-013 pending  output  NCH  per-channel pending-event bits.

Function
REQ-014 Base tick SHALL be tick_lvl & ~tick_q, tick_q a register of tick_lvl; falling edges SHALL be ignored.
REQ-015 Each channel SHALL hold a PW-bit down-counter cnt[i].
REQ-016 Channel i SHALL be active only when cfg_en[i]=1 and cfg_period[i]!=0; period 0 SHALL behave as disabled.
REQ-017 Inactive channel: cnt[i] <= cfg_period[i]-1 (0 when period 0) every cycle, pending[i] cleared unless accepted same cycle, no events.
REQ-018 Active channel on base tick: cnt[i]==0 -> set pending[i], cnt[i] <= cfg_period[i]-1; else cnt[i] decrements.
REQ-019 Period 1 SHALL fire on every base tick; period P SHALL fire every P base ticks, first fire P base ticks after activation.
REQ-020 FSM states IDLE and OFFER; IDLE -> OFFER when any pending bit is set; OFFER -> IDLE on evt_valid & evt_ready.
REQ-021 evt_valid SHALL be 1 exactly in OFFER; evt_ch SHALL be latched on IDLE->OFFER and held stable until acceptance.
REQ-022 Channel selection SHALL be round-robin: lowest pending index at or above rr_ptr, wrapping; rr_ptr <= granted index+1 (mod NCH) on acceptance.
REQ-023 On acceptance, pending[evt_ch] SHALL clear, unless the same channel fires in that cycle, in which case it remains set and no overrun is flagged.
REQ-024 A fire on a channel whose pending bit is already set and not being accepted that cycle SHALL set ovr_flag[i]; the event is merged (not queued).
REQ-025 ovr_clr[i] SHALL clear ovr_flag[i]; simultaneous set and clear SHALL leave the flag set.
REQ-026 Disabling a channel while it is offered SHALL NOT withdraw evt_valid; the offer completes normally.
REQ-027 Latency: base tick at edge t sets pending at t; evt_valid high after edge t+1 when FSM was IDLE.
REQ-028 Back-to-back: after acceptance, IDLE lasts one cycle minimum before next OFFER.

Reset
REQ-029 rst_n low SHALL asynchronously force: tick_q=0, all cnt[i]=0, pending=0, ovr_flag=0, rr_ptr=0, FSM=IDLE, evt_valid=0, evt_ch=0.
REQ-030 After rst_n release, counters SHALL load cfg_period-1 on the first cycle; a tick_lvl already high at release SHALL produce one base tick only if tick_q was 0 (i.e., counts as an edge).
REQ-031 Reset mid-OFFER SHALL drop evt_valid immediately; the event is lost.

Verification
REQ-032 NCH=4, ch0 period 3 enabled, evt_ready=1, 9 tick_lvl rising edges -> exactly 3 events, evt_ch=0, each evt_valid 2 cycles after the firing edge.
REQ-033 All 4 channels period 1, evt_ready=1 -> events in order ch0,ch1,ch2,ch3 per round-robin; ovr_flag set on channels still pending at next tick.
REQ-034 ch2 period 1, evt_ready=0 over 2 ticks -> evt_valid held, evt_ch=2 stable, ovr_flag[2]=1; ovr_clr[2] pulse -> flag 0.
REQ-035 ch1 period 0 with cfg_en=1 over 10 ticks -> no events, pending[1]=0.
REQ-036 Assert rst_n low during OFFER -> evt_valid=0, pending=0, ovr_flag=0 same cycle; release with ch0 period 2 -> first event after 2 ticks.
REQ-037 Same-cycle ovr_clr[i] and overrun on channel i -> ovr_flag[i]=1.
